// File: rtl/cr_iu_gated_reg_wr_arb.sv
// cr_iu_gated_reg_wr_arb
//   Write-port arbiter/sequencer for a single-write-port, clock-gated 32-bit IU
//   register. NREQ requesters share the port through valid/ready handshakes.
//   A requester may lock the port across several transfers. If the owner stays
//   idle for LOCK_MAX cycles, the lock is released by force. The write enable
//   and data are registered, so the gated-clock register downstream sees clean
//   enables.
//
//   Build option: CR_IU_WR_ARB_FIXED_PRIO_EN
//     Defined     -> the IDLE grant is fixed priority (requester 0 highest) and
//                    there is no round-robin pointer.
//     Not defined -> the IDLE grant is round-robin, starting from rr_ptr.
//
// Ports
//   forever_cpuclk  free-running clock; all state changes on its rising edge
//   cpurst          synchronous active-high reset
//   req_vld         per-requester write request valid
//   req_lock        requester keeps ownership after this transfer
//   req_data        packed write data; requester i uses [32*i+31:32*i]
//   req_rdy         one-hot grant (combinational)
//   arb_stall       blocks all grants and freezes the arbiter state
//   x_write_en      registered write enable to the gated register
//   write_data      registered write data to the gated register
//   arb_busy        high while LOCKED or while x_write_en is high
//   arb_owner       index of the last granted requester
module cr_iu_gated_reg_wr_arb #(
  parameter int NREQ     = 3,
  parameter int IDX_W    = 2,
  parameter int LOCK_MAX = 15
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_rdy,
  input  logic                 arb_stall,
  output logic                 x_write_en,
  output logic [31:0]          write_data,
  output logic                 arb_busy,
  output logic [IDX_W-1:0]     arb_owner
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   cand;
  int unsigned        sum;
  logic               found;
  logic               xfer;
  logic [31:0]        data_arr [NREQ];
  logic [31:0]        gdata;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
    assign data_arr[gi] = req_data[32*gi +: 32];
  end

`ifdef CR_IU_WR_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_nxt;

  assign rr_ptr_nxt = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end
`endif

  // Grant selection. The sum is wrapped explicitly, so rr_ptr + k never
  // overflows IDX_W before the modulo is applied.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    sum   = 0;
    found = 1'b0;
    if (!cpurst && !arb_stall) begin
      if (state == LOCKED) begin
        grant[arb_owner] = req_vld[arb_owner];
        gidx             = arb_owner;
      end else begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          sum = 32'(rr_ptr) + k;
          if (sum >= NREQ) begin
            sum = sum - NREQ;
          end
          cand = IDX_W'(sum);
          if (!found && req_vld[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
          end
        end
      end
    end
  end

  assign req_rdy = grant;
  assign xfer    = |grant;
  assign gdata   = data_arr[gidx];

  // An owner transfer takes priority over timeout and release, so a transfer
  // in the same cycle as the timeout keeps the lock alive.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (xfer) begin
      state_nxt    = req_lock[gidx] ? LOCKED : IDLE;
      lock_cnt_nxt = '0;
    end else if (state == LOCKED && !arb_stall) begin
      if (!req_lock[arb_owner]) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end else begin
        lock_cnt_nxt = lock_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      x_write_en <= 1'b0;
      write_data <= '0;
      arb_owner  <= '0;
    end else begin
      x_write_en <= xfer;
      if (xfer) begin
        write_data <= gdata;
        arb_owner  <= gidx;
      end
    end
  end

  assign arb_busy = (state == LOCKED) || x_write_en;

endmodule
